// File: rtl/demux1to6_16b_reg_if.sv
// Write-side bus of the registered 1-to-6 demultiplexer.
//   master : source side, drives I/S/V/AUTO/CLR and observes RDY and slot state
//   slave  : demux side, receives the write/consume controls and drives
//            RDY, the six slot registers A..F, VLD, IDX, DONE and ERR
interface demux1to6_16b_reg_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] I;
  logic [2:0]       S;
  logic             V;
  logic             AUTO;
  logic             RDY;
  logic [5:0]       CLR;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] E;
  logic [WIDTH-1:0] F;
  logic [5:0]       VLD;
  logic [2:0]       IDX;
  logic             DONE;
  logic             ERR;

  modport master (
    output I, S, V, AUTO, CLR,
    input  RDY, A, B, C, D, E, F, VLD, IDX, DONE, ERR
  );

  modport slave (
    input  I, S, V, AUTO, CLR,
    output RDY, A, B, C, D, E, F, VLD, IDX, DONE, ERR
  );
endinterface

// File: rtl/demux1to6_16b_reg.sv
// Registered 1-to-6 demultiplexer: steers one input word per cycle into one
// of six holding registers A..F, with per-slot occupancy flags, a
// valid/ready handshake, per-slot consume strobes and an auto-increment
// fill mode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state including slots
//   bus   : slave side of demux1to6_16b_reg_if (I, S, V, AUTO, CLR in;
//           RDY, A..F, VLD, IDX, DONE, ERR out)
module demux1to6_16b_reg #(
  parameter int WIDTH = 16,
  parameter int NSLOT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1to6_16b_reg_if.slave    bus
);

  localparam logic [NSLOT-1:0] FULL     = {NSLOT{1'b1}};
  localparam logic [2:0]       LAST_IDX = 3'(NSLOT - 1);

  logic [WIDTH-1:0] slot [NSLOT];
  logic [NSLOT-1:0] vld;
  logic [2:0]       idx;
  logic             done;
  logic             err;

  logic [2:0]       tgt;
  logic             legal;
  logic             rdy;
  logic             acc;
  logic [NSLOT-1:0] wr_sel;
  logic [NSLOT-1:0] vld_nxt;

  // Target selection and handshake. An illegal manual select is still
  // accepted (RDY=1) so the source never deadlocks; the write is dropped
  // and only flagged through ERR.
  always_comb begin
    tgt     = bus.AUTO ? idx : bus.S;
    legal   = (tgt <= LAST_IDX);
    rdy     = 1'b1;
    if (legal) begin
      rdy = ~vld[tgt] | bus.CLR[tgt];
    end
    acc     = bus.V & rdy;
    wr_sel  = '0;
    if (acc && legal) begin
      wr_sel = NSLOT'(1) << tgt;
    end
    // Write wins over a same-cycle consume of the same slot.
    vld_nxt = (vld & ~bus.CLR) | wr_sel;
  end

  // Slot, flag and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) begin
        slot[k] <= '0;
      end
      vld  <= '0;
      idx  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        if (wr_sel[k]) begin
          slot[k] <= bus.I;
        end
      end
      vld  <= vld_nxt;
      // Rising-edge detect on "all slots full" so DONE fires only once.
      done <= (vld_nxt == FULL) && (vld != FULL);
      if (acc && !legal) begin
        err <= 1'b1;
      end
      // AUTO targets are always legal, so acceptance implies a real write.
      if (acc && bus.AUTO) begin
        idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  assign bus.RDY  = rdy;
  assign bus.A    = slot[0];
  assign bus.B    = slot[1];
  assign bus.C    = slot[2];
  assign bus.D    = slot[3];
  assign bus.E    = slot[4];
  assign bus.F    = slot[5];
  assign bus.VLD  = vld;
  assign bus.IDX  = idx;
  assign bus.DONE = done;
  assign bus.ERR  = err;

endmodule

// File: doc/demux1to6_16b_reg.md
Name: demux1to6_16b_reg

Overview:
Registered 1-to-6, 16-bit demultiplexer. It is the write-side counterpart of the 6:1 16-bit operand mux in the square-root datapath. It steers one 16-bit input word into one of six holding registers, A..F, which feed the mux inputs. It tracks per-slot occupancy with a valid/ready handshake and offers an auto-increment fill mode for loading all six slots in sequence.

Parameters:
WIDTH, 16, data width of input and of each slot register
NSLOT, 6, number of slots; fixed at 6, not to be overridden

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  reset, asynchronous, active-low
I  in  16  write data
S  in  3  slot select in manual mode: 000=A, 001=B, 010=C, 011=D, 100=E, 101=F; 110/111 illegal
V  in  1  write valid
AUTO  in  1  1 = slot chosen by internal counter IDX and S ignored; 0 = slot chosen by S
RDY  out  1  write ready (combinational)
CLR  in  6  per-slot consume strobe; bit0=A .. bit5=F
A, B, C, D, E, F  out  16 each  slot registers
VLD  out  6  slot-full flags; bit0=A .. bit5=F
IDX  out  3  next slot index used in auto mode
DONE  out  1  one-cycle pulse when VLD becomes 6'b111111
ERR  out  1  sticky illegal-select flag

Behaviour:
- Reset (rst_n=0, asynchronous) sets A..F=16'h0000, VLD=0, IDX=0, DONE=0, ERR=0. This applies at any time, including mid-sequence. All state is restored on the next clock after release.
- Target slot k: k=IDX if AUTO=1, else k=S.
- RDY (combinational):
  - Legal k: RDY = ~VLD[k] | CLR[k].
  - Illegal k (manual mode, S=110/111): RDY=1, so the write is accepted and dropped.
- Write accepted when V & RDY on a rising edge.
- Legal accepted write, effects on the next edge:
  - slot k <= I
  - VLD[k] <= 1
  - 1-cycle latency from acceptance to visible data and flag.
- Illegal accepted write: no slot, VLD or IDX change; ERR <= 1. ERR stays set until reset.
- V=1 & RDY=0: stall. Nothing changes; the source holds I/S/V.
- CLR[j]=1 with no accepted write to j: VLD[j] <= 0 next edge. Slot data is retained, not zeroed.
- CLR[j] and an accepted write to j on the same edge: the write wins. Data is updated and VLD[j] stays 1.
- CLR of an empty slot: no effect.
- Auto mode:
  - IDX advances only on an accepted write with AUTO=1.
  - Sequence is 0,1,2,3,4,5 and then wraps 5 -> 0.
  - AUTO=0 freezes IDX.
  - Toggling AUTO between cycles is legal and does not reset IDX.
- DONE: registered; pulses 1 for exactly one cycle on the edge where VLD transitions from not-all-ones to 6'b111111. It does not repeat while VLD stays all-ones.
- Writes to different slots never corrupt each other. At most one write per cycle.

Test Plan:
- Manual fill: AUTO=0, V=1, writes S=000..101 with I=0000,00AB,00BC,00CD,00DE,00EF -> A..F hold those values one cycle after each write; VLD reaches 3F; DONE pulses once on the sixth write; ERR=0.
- Stall and consume: A full, manual write S=000, I=1234 -> RDY=0, A stays 0000. Assert CLR[0] in the same cycle -> write accepted, A=1234, VLD[0]=1. Then CLR[0] alone -> VLD[0]=0, A still 1234.
- Illegal select: manual writes with S=110 and S=111 -> RDY=1, A..F and VLD unchanged, ERR=1 and sticky across 10 further cycles.
- Auto fill with wrap:
  - AUTO=1, seven writes 0001..0007, with CLR[0] pulsed before the seventh -> IDX goes 0..5 then 0; A=0007, F=0006.
  - DONE pulses once after the sixth write.
- Auto stall: AUTO=1, IDX=2, slot C full, V=1 -> RDY=0 and IDX stays 2 until CLR[2].
- Reset mid-operation: drop rst_n asynchronously, between clock edges, after three auto writes -> all outputs zero immediately. After release, a write with AUTO=1 lands in A.
